// File: rtl/iob_uart16550_ctrl_pkg.sv
// Shared constants, states and init-sequence helpers for the iob_uart16550 controller.
// Build option: IOB_UART16550_CTRL_IRQ_EN selects the IER value written during init.
package iob_uart16550_ctrl_pkg;

    // 16550 register byte offsets
    localparam logic [2:0] REG_RBR = 3'd0;
    localparam logic [2:0] REG_THR = 3'd0;
    localparam logic [2:0] REG_DLL = 3'd0;
    localparam logic [2:0] REG_IER = 3'd1;
    localparam logic [2:0] REG_DLM = 3'd1;
    localparam logic [2:0] REG_FCR = 3'd2;
    localparam logic [2:0] REG_LCR = 3'd3;
    localparam logic [2:0] REG_LSR = 3'd5;

    // LSR bit positions
    localparam int LSR_DR      = 0;
    localparam int LSR_ERR_LO  = 1;
    localparam int LSR_ERR_HI  = 4;
    localparam int LSR_THRE    = 5;

    localparam logic [7:0] LCR_DLAB  = 8'h80;
    localparam logic [7:0] FCR_INIT  = 8'h07;
`ifdef IOB_UART16550_CTRL_IRQ_EN
    localparam logic [7:0] IER_INIT  = 8'h01;
`else
    localparam logic [7:0] IER_INIT  = 8'h00;
`endif

    localparam logic [2:0] INIT_LAST = 3'd5;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_TX_LSR,
        S_TX_WR,
        S_RX_LSR,
        S_RX_RD
    } ctrl_state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_REQ,
        B_WAIT
    } bus_state_t;

    // Register offset written at each init step
    function automatic logic [2:0] init_off(input logic [2:0] step);
        case (step)
            3'd0:    return REG_LCR;
            3'd1:    return REG_DLL;
            3'd2:    return REG_DLM;
            3'd3:    return REG_LCR;
            3'd4:    return REG_FCR;
            default: return REG_IER;
        endcase
    endfunction

    // Data byte written at each init step
    function automatic logic [7:0] init_byte(input logic [2:0] step, input logic [15:0] div,
                                             input logic [7:0] lcr);
        case (step)
            3'd0:    return LCR_DLAB | lcr;
            3'd1:    return div[7:0];
            3'd2:    return div[15:8];
            3'd3:    return lcr;
            3'd4:    return FCR_INIT;
            default: return IER_INIT;
        endcase
    endfunction

endpackage

// File: rtl/iob_uart16550_ctrl_bus.sv
// Single-access CSR master: owns the valid/ready/rvalid handshake and byte-lane steering.
module iob_uart16550_ctrl_bus #(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_n_i,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic              read,
    output logic              done,
    output logic [7:0]        rbyte,
    output logic              uart_valid_o,
    output logic [ADDR_W-1:0] uart_addr_o,
    output logic [31:0]       uart_wdata_o,
    output logic [3:0]        uart_wstrb_o,
    input  logic              uart_ready_i,
    input  logic              uart_rvalid_i,
    input  logic [31:0]       uart_rdata_i
);
    import iob_uart16550_ctrl_pkg::*;

    bus_state_t st, st_nxt;
    logic       read_q;

    // Handshake sequencing; done fires on the cycle the access completes
    always_comb begin
        st_nxt = st;
        done   = 1'b0;
        case (st)
            B_IDLE: if (start) st_nxt = B_REQ;
            B_REQ: begin
                if (uart_ready_i) begin
                    if (!read_q || uart_rvalid_i) begin
                        done   = 1'b1;
                        st_nxt = B_IDLE;
                    end else begin
                        st_nxt = B_WAIT;
                    end
                end
            end
            B_WAIT: begin
                if (uart_rvalid_i) begin
                    done   = 1'b1;
                    st_nxt = B_IDLE;
                end
            end
            default: st_nxt = B_IDLE;
        endcase
    end

    // State, valid and request fields; fields are latched once per access so they stay stable
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            st           <= B_IDLE;
            read_q       <= 1'b0;
            uart_valid_o <= 1'b0;
            uart_addr_o  <= '0;
            uart_wdata_o <= '0;
            uart_wstrb_o <= '0;
        end else if (cke_i) begin
            st           <= st_nxt;
            uart_valid_o <= (st_nxt == B_REQ);
            if (st == B_IDLE && start) begin
                read_q       <= read;
                uart_addr_o  <= addr;
                uart_wdata_o <= {4{wdata}};
                uart_wstrb_o <= read ? 4'b0000 : (4'b0001 << addr[1:0]);
            end
        end
    end

    // Pick the read byte from the lane addressed by the current access
    always_comb begin
        case (uart_addr_o[1:0])
            2'd0:    rbyte = uart_rdata_i[7:0];
            2'd1:    rbyte = uart_rdata_i[15:8];
            2'd2:    rbyte = uart_rdata_i[23:16];
            default: rbyte = uart_rdata_i[31:24];
        endcase
    end

endmodule

// File: rtl/iob_uart16550_ctrl.sv
// iob_uart16550 sequencer: init programming, then TX/RX byte streaming over one CSR port.
// Build option: IOB_UART16550_CTRL_IRQ_EN gates RX polling on interrupt_i and enables the RX IRQ.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_INIT   | writing init register sequence, step 0..5
// S_IDLE   | arbitrating TX/RX, accepting cfg_start_i
// S_TX_LSR | reading LSR to check THRE
// S_TX_WR  | writing tx byte to THR
// S_RX_LSR | reading LSR to check DR and error bits
// S_RX_RD  | reading RBR into rx_data_o
module iob_uart16550_ctrl #(
    parameter logic [15:0] DIV_RST = 16'h001B,
    parameter logic [7:0]  LCR_VAL = 8'h03,
    parameter int          ADDR_W  = 5
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_n_i,
    input  logic              cfg_start_i,
    input  logic [15:0]       cfg_div_i,
    output logic              cfg_done_o,
    input  logic [7:0]        tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [7:0]        rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              rx_err_o,
    output logic              uart_valid_o,
    output logic [ADDR_W-1:0] uart_addr_o,
    output logic [31:0]       uart_wdata_o,
    output logic [3:0]        uart_wstrb_o,
    input  logic              uart_ready_i,
    input  logic              uart_rvalid_i,
    input  logic [31:0]       uart_rdata_i,
    input  logic              interrupt_i
);
    import iob_uart16550_ctrl_pkg::*;

    ctrl_state_t state, state_nxt;
    logic [2:0]  step, step_nxt;
    logic        issued, issued_nxt;
    logic [15:0] div_q, div_nxt;
    logic        last_tx, last_tx_nxt;
    logic        lsr_err, lsr_err_nxt;
    logic        cfg_done_nxt, tx_ready_nxt, rx_valid_nxt, rx_err_nxt;
    logic [7:0]  rx_data_nxt;

    logic        bus_start, bus_read, bus_done;
    logic [2:0]  bus_off;
    logic [7:0]  bus_wdata, bus_rbyte;
    logic        tx_cand, rx_cand;

    // TX is masked while tx_ready_o is high: the client retires that byte this cycle
    assign tx_cand = tx_valid_i && !tx_ready_o;
`ifdef IOB_UART16550_CTRL_IRQ_EN
    assign rx_cand = !rx_valid_o && interrupt_i;
`else
    assign rx_cand = !rx_valid_o;
    logic unused_irq;
    assign unused_irq = interrupt_i;
`endif

    // Access request for the current state; issued once on state entry
    always_comb begin
        bus_off   = REG_LSR;
        bus_wdata = 8'h00;
        bus_read  = 1'b1;
        case (state)
            S_INIT: begin
                bus_off   = init_off(step);
                bus_wdata = init_byte(step, div_q, LCR_VAL);
                bus_read  = 1'b0;
            end
            S_TX_WR: begin
                bus_off   = REG_THR;
                bus_wdata = tx_data_i;
                bus_read  = 1'b0;
            end
            S_RX_RD: bus_off = REG_RBR;
            default: ;
        endcase
        bus_start = (state != S_IDLE) && !issued;
    end

    // Next-state and output update
    always_comb begin
        state_nxt    = state;
        step_nxt     = step;
        issued_nxt   = issued;
        div_nxt      = div_q;
        last_tx_nxt  = last_tx;
        lsr_err_nxt  = lsr_err;
        cfg_done_nxt = cfg_done_o;
        tx_ready_nxt = 1'b0;
        rx_data_nxt  = rx_data_o;
        rx_valid_nxt = rx_valid_o;
        rx_err_nxt   = rx_err_o;

        if (bus_done)       issued_nxt = 1'b0;
        else if (bus_start) issued_nxt = 1'b1;

        if (rx_valid_o && rx_ready_i) rx_valid_nxt = 1'b0;

        case (state)
            S_INIT: begin
                if (bus_done) begin
                    if (step == INIT_LAST) begin
                        step_nxt     = 3'd0;
                        cfg_done_nxt = 1'b1;
                        state_nxt    = S_IDLE;
                    end else begin
                        step_nxt = step + 3'd1;
                    end
                end
            end
            S_IDLE: begin
                if (cfg_start_i) begin
                    div_nxt      = cfg_div_i;
                    cfg_done_nxt = 1'b0;
                    rx_err_nxt   = 1'b0;
                    step_nxt     = 3'd0;
                    state_nxt    = S_INIT;
                end else if (cfg_done_o) begin
                    if (tx_cand && (!rx_cand || !last_tx)) begin
                        last_tx_nxt = 1'b1;
                        state_nxt   = S_TX_LSR;
                    end else if (rx_cand) begin
                        last_tx_nxt = 1'b0;
                        state_nxt   = S_RX_LSR;
                    end
                end
            end
            S_TX_LSR: begin
                if (bus_done) state_nxt = bus_rbyte[LSR_THRE] ? S_TX_WR : S_IDLE;
            end
            S_TX_WR: begin
                if (bus_done) begin
                    tx_ready_nxt = 1'b1;
                    state_nxt    = S_IDLE;
                end
            end
            S_RX_LSR: begin
                if (bus_done) begin
                    lsr_err_nxt = |bus_rbyte[LSR_ERR_HI:LSR_ERR_LO];
                    state_nxt   = bus_rbyte[LSR_DR] ? S_RX_RD : S_IDLE;
                end
            end
            S_RX_RD: begin
                if (bus_done) begin
                    rx_data_nxt  = bus_rbyte;
                    rx_valid_nxt = 1'b1;
                    rx_err_nxt   = rx_err_o | lsr_err;
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // State and output registers, frozen while cke_i is low
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state      <= S_INIT;
            step       <= 3'd0;
            issued     <= 1'b0;
            div_q      <= DIV_RST;
            last_tx    <= 1'b0;
            lsr_err    <= 1'b0;
            cfg_done_o <= 1'b0;
            tx_ready_o <= 1'b0;
            rx_data_o  <= 8'h00;
            rx_valid_o <= 1'b0;
            rx_err_o   <= 1'b0;
        end else if (cke_i) begin
            state      <= state_nxt;
            step       <= step_nxt;
            issued     <= issued_nxt;
            div_q      <= div_nxt;
            last_tx    <= last_tx_nxt;
            lsr_err    <= lsr_err_nxt;
            cfg_done_o <= cfg_done_nxt;
            tx_ready_o <= tx_ready_nxt;
            rx_data_o  <= rx_data_nxt;
            rx_valid_o <= rx_valid_nxt;
            rx_err_o   <= rx_err_nxt;
        end
    end

    iob_uart16550_ctrl_bus #(.ADDR_W(ADDR_W)) u_bus (
        .clk_i         (clk_i),
        .cke_i         (cke_i),
        .arst_n_i      (arst_n_i),
        .start         (bus_start),
        .addr          (ADDR_W'(bus_off)),
        .wdata         (bus_wdata),
        .read          (bus_read),
        .done          (bus_done),
        .rbyte         (bus_rbyte),
        .uart_valid_o  (uart_valid_o),
        .uart_addr_o   (uart_addr_o),
        .uart_wdata_o  (uart_wdata_o),
        .uart_wstrb_o  (uart_wstrb_o),
        .uart_ready_i  (uart_ready_i),
        .uart_rvalid_i (uart_rvalid_i),
        .uart_rdata_i  (uart_rdata_i)
    );

endmodule
